control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 150 +++++++++++++++
 tb/tb_control_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Instruction control sequencer: fetch / load / decode / multi-step execute with
// stall freezing, interrupt entry at instruction boundaries and illegal-opcode trap.
module control_sequencer #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int STEP_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic              mem_ready,
  input  logic              stall,
  input  logic              irq,
  input  logic [3:0]        status_reg,
  output logic [2:0]        state,
  output logic [STEP_W-1:0] step,
  output logic [OPC_W-1:0]  opcode,
  output logic              mem_req,
  output logic              ir_load,
  output logic              pc_inc,
  output logic              exec_active,
  output logic              branch_taken,
  output logic              illegal,
  output logic              irq_ack
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOAD_IR = 3'd2;
  localparam logic [2:0] S_DECODE  = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_IRQ     = 3'd5;

  localparam logic [OPC_W-1:0] OPC_ILLEGAL = OPC_W'(7);

  // Index of the final EXEC step; conditional branches run long only when taken.
  function automatic logic [STEP_W-1:0] last_step(input logic [OPC_W-1:0] opc,
                                                  input logic taken);
    case (opc)
      OPC_W'(2), OPC_W'(3), OPC_W'(4), OPC_W'(11): last_step = STEP_W'(2);
      OPC_W'(8), OPC_W'(9):                        last_step = STEP_W'(3);
      OPC_W'(10):                                  last_step = STEP_W'(5);
      OPC_W'(12):                                  last_step = STEP_W'(1);
      OPC_W'(13), OPC_W'(14), OPC_W'(15):          last_step = taken ? STEP_W'(2) : STEP_W'(0);
      default:                                     last_step = STEP_W'(0);
    endcase
  endfunction

  function automatic logic branch_cond(input logic [OPC_W-1:0] opc, input logic [3:0] flags);
    case (opc)
      OPC_W'(13): branch_cond = flags[1];
      OPC_W'(14): branch_cond = flags[3];
      OPC_W'(15): branch_cond = flags[2];
      default:    branch_cond = 1'b0;
    endcase
  endfunction

  logic [2:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic [OPC_W-1:0]  ir_q, ir_d;
  logic              branch_q, branch_d;
  logic              mem_req_q, mem_req_d;
  logic              ir_load_q, ir_load_d;
  logic              pc_inc_q, pc_inc_d;
  logic              illegal_q, illegal_d;
  logic              irq_ack_q, irq_ack_d;
  logic              exec_last;
  logic              instr_unused;

  // Only the opcode field of the fetched word steers the sequencer.
  assign instr_unused = ^instr[INSTR_W-OPC_W-1:0];
  assign exec_last    = (step_q == last_step(opcode_q, branch_q));

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      opcode_q  <= '0;
      ir_q      <= '0;
      branch_q  <= 1'b0;
      mem_req_q <= 1'b0;
      ir_load_q <= 1'b0;
      pc_inc_q  <= 1'b0;
      illegal_q <= 1'b0;
      irq_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      opcode_q  <= opcode_d;
      ir_q      <= ir_d;
      branch_q  <= branch_d;
      mem_req_q <= mem_req_d;
      ir_load_q <= ir_load_d;
      pc_inc_q  <= pc_inc_d;
      illegal_q <= illegal_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  // Next-state logic; irq is only looked at on the final unstalled EXEC step.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH:   state_d = mem_ready ? S_LOAD_IR : S_FETCH;
      S_LOAD_IR: state_d = S_DECODE;
      S_DECODE:  state_d = (ir_q == OPC_ILLEGAL) ? S_FETCH : S_EXEC;
      S_EXEC: begin
        if (!stall && exec_last) begin
          state_d = irq ? S_IRQ : S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_IRQ:     state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and strobe next values; strobes follow the upcoming state so they are registered.
  always_comb begin
    ir_d     = (state_q == S_FETCH && mem_ready) ? instr[INSTR_W-1 -: OPC_W] : ir_q;
    opcode_d = (state_q == S_DECODE) ? ir_q : opcode_q;
    branch_d = (state_q == S_DECODE) ? branch_cond(ir_q, status_reg) : branch_q;
    if (state_q == S_EXEC && state_d == S_EXEC) begin
      step_d = stall ? step_q : step_q + STEP_W'(1);
    end else begin
      step_d = '0;
    end
    mem_req_d = (state_d == S_FETCH);
    ir_load_d = (state_d == S_LOAD_IR);
    pc_inc_d  = (state_d == S_LOAD_IR);
    irq_ack_d = (state_d == S_IRQ);
    illegal_d = (state_q == S_DECODE) && (ir_q == OPC_ILLEGAL);
  end

  assign state        = state_q;
  assign step         = step_q;
  assign opcode       = opcode_q;
  assign mem_req      = mem_req_q;
  assign ir_load      = ir_load_q;
  assign pc_inc       = pc_inc_q;
  assign branch_taken = branch_q;
  assign illegal      = illegal_q;
  assign irq_ack      = irq_ack_q;
  assign exec_active  = (state_q == S_EXEC) && !stall;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected records are queued
// with their stimulus, then applied and compared one cycle at a time.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] instr = 16'd0;
  logic        mem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        irq = 1'b0;
  logic [3:0]  status_reg = 4'd0;
  logic [2:0]  state;
  logic [2:0]  step;
  logic [3:0]  opcode;
  logic        mem_req, ir_load, pc_inc, exec_active, branch_taken, illegal, irq_ack;

  control_sequencer #(.INSTR_W(16), .OPC_W(4), .STEP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .stall(stall),
    .irq(irq), .status_reg(status_reg), .state(state), .step(step), .opcode(opcode),
    .mem_req(mem_req), .ir_load(ir_load), .pc_inc(pc_inc), .exec_active(exec_active),
    .branch_taken(branch_taken), .illegal(illegal), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic [2:0] step;
    logic [3:0] opcode;
    logic mem_req, ir_load, pc_inc, exec_active, branch_taken, illegal, irq_ack;
  } exp_t;

  typedef struct packed {
    logic        mem_ready, stall, irq;
    logic [15:0] instr;
    logic [3:0]  status;
    exp_t        e;
  } rec_t;

  rec_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  cur_opc = 4'd0;
  logic        cur_br = 1'b0;
  logic        pend_ill = 1'b0;
  logic [15:0] cur_instr = 16'd0;
  logic [3:0]  cur_status = 4'd0;

  function automatic exp_t observe();
    exp_t o;
    o = {state, step, opcode, mem_req, ir_load, pc_inc, exec_active, branch_taken, illegal, irq_ack};
    return o;
  endfunction

  function automatic int exec_len(input logic [3:0] opc, input logic br);
    case (opc)
      4'd0, 4'd1, 4'd5, 4'd6:   return 1;
      4'd2, 4'd3, 4'd4, 4'd11:  return 3;
      4'd8, 4'd9:               return 4;
      4'd10:                    return 6;
      4'd12:                    return 2;
      4'd13, 4'd14, 4'd15:      return br ? 3 : 1;
      default:                  return 0;
    endcase
  endfunction

  task automatic add_rec(input logic [2:0] st, input int stp, input logic mr,
                         input logic sl, input logic iq);
    rec_t r;
    r.mem_ready      = mr;
    r.stall          = sl;
    r.irq            = iq;
    r.instr          = cur_instr;
    r.status         = cur_status;
    r.e.state        = st;
    r.e.step         = 3'(stp);
    r.e.opcode       = cur_opc;
    r.e.mem_req      = (st == 3'd1);
    r.e.ir_load      = (st == 3'd2);
    r.e.pc_inc       = (st == 3'd2);
    r.e.exec_active  = (st == 3'd4) && !sl;
    r.e.branch_taken = cur_br;
    r.e.illegal      = pend_ill;
    r.e.irq_ack      = (st == 3'd5);
    pend_ill = 1'b0;
    sb.push_back(r);
  endtask

  // Queue the expected cycle-by-cycle trace of one instruction, starting at its first FETCH cycle.
  task automatic gen(input logic [3:0] opc, input logic [3:0] stat, input int fwait,
                     input int stall_at, input int stall_n, input int irq_at);
    int len;
    cur_instr  = {opc, 12'($urandom)};
    cur_status = stat;
    repeat (fwait) add_rec(3'd1, 0, 1'b0, 1'b0, 1'b0);
    add_rec(3'd1, 0, 1'b1, 1'b0, 1'b0);
    add_rec(3'd2, 0, 1'b0, 1'b0, 1'b0);
    add_rec(3'd3, 0, 1'b0, 1'b0, 1'b0);
    cur_opc = opc;
    cur_br  = (opc == 4'd13) ? stat[1] : (opc == 4'd14) ? stat[3] : (opc == 4'd15) ? stat[2] : 1'b0;
    if (opc == 4'd7) begin
      pend_ill = 1'b1;
    end else begin
      len = exec_len(opc, cur_br);
      for (int s = 0; s < len; s++) begin
        if (s == stall_at) begin
          repeat (stall_n) add_rec(3'd4, s, 1'b0, 1'b1, (irq_at >= 0) && (s >= irq_at));
        end
        add_rec(3'd4, s, 1'b0, 1'b0, (irq_at >= 0) && (s >= irq_at));
      end
      if (irq_at >= 0) add_rec(3'd5, 0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    exp_t o;
    #2 rst_n = 1'b0;
    #1 o = observe();
    checks++;
    if (o !== 17'd0) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", o, 17'd0);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_add();
    rec_t r; exp_t o; int n;
    gen(4'd2, 4'd0, 0, -1, 0, -1);
    n = 0;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      @(posedge clk); #1;
      mem_ready = r.mem_ready; stall = r.stall; irq = r.irq; instr = r.instr; status_reg = r.status;
      #1 o = observe();
      checks++; n++;
      if (o !== r.e) begin
        errors++;
        $display("FAIL add cyc %0d got %h exp %h", n, o, r.e);
      end
    end
  endtask

  task automatic test_branch();
    rec_t r; exp_t o; int n;
    gen(4'd13, 4'b0010, 0, -1, 0, -1);
    gen(4'd13, 4'b1101, 1, -1, 0, -1);
    gen(4'd14, 4'b1000, 0, -1, 0, -1);
    gen(4'd14, 4'b0111, 0, -1, 0, -1);
    gen(4'd15, 4'b0100, 0, 1, 1, -1);
    gen(4'd15, 4'b1011, 0, -1, 0, -1);
    gen(4'd1, 4'b0010, 0, -1, 0, -1);
    n = 0;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      @(posedge clk); #1;
      mem_ready = r.mem_ready; stall = r.stall; irq = r.irq; instr = r.instr; status_reg = r.status;
      #1 o = observe();
      checks++; n++;
      if (o !== r.e) begin
        errors++;
        $display("FAIL branch cyc %0d got %h exp %h", n, o, r.e);
      end
    end
  endtask

  task automatic test_stall();
    rec_t r; exp_t o; int n;
    gen(4'd10, 4'd0, 1, 3, 2, -1);
    n = 0;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      @(posedge clk); #1;
      mem_ready = r.mem_ready; stall = r.stall; irq = r.irq; instr = r.instr; status_reg = r.status;
      #1 o = observe();
      checks++; n++;
      if (o !== r.e) begin
        errors++;
        $display("FAIL stall cyc %0d got %h exp %h", n, o, r.e);
      end
    end
  endtask

  task automatic test_illegal();
    rec_t r; exp_t o; int n;
    gen(4'd7, 4'd0, 0, -1, 0, -1);
    gen(4'd0, 4'd0, 2, -1, 0, -1);
    n = 0;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      @(posedge clk); #1;
      mem_ready = r.mem_ready; stall = r.stall; irq = r.irq; instr = r.instr; status_reg = r.status;
      #1 o = observe();
      checks++; n++;
      if (o !== r.e) begin
        errors++;
        $display("FAIL illegal cyc %0d got %h exp %h", n, o, r.e);
      end
    end
  endtask

  task automatic test_irq();
    rec_t r; exp_t o; int n;
    gen(4'd8, 4'd0, 0, -1, 0, 1);
    gen(4'd12, 4'd0, 0, 1, 1, 1);
    gen(4'd5, 4'd0, 0, -1, 0, -1);
    n = 0;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      @(posedge clk); #1;
      mem_ready = r.mem_ready; stall = r.stall; irq = r.irq; instr = r.instr; status_reg = r.status;
      #1 o = observe();
      checks++; n++;
      if (o !== r.e) begin
        errors++;
        $display("FAIL irq cyc %0d got %h exp %h", n, o, r.e);
      end
    end
  endtask

  task automatic test_back_to_back();
    rec_t r; exp_t o; int n;
    for (int k = 0; k < 32; k++) begin
      gen(4'(k), 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 6),
          $urandom_range(1, 2), (k % 3 == 0) ? 0 : -1);
    end
    n = 0;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      @(posedge clk); #1;
      mem_ready = r.mem_ready; stall = r.stall; irq = r.irq; instr = r.instr; status_reg = r.status;
      #1 o = observe();
      checks++; n++;
      if (o !== r.e) begin
        errors++;
        $display("FAIL b2b cyc %0d got %h exp %h", n, o, r.e);
      end
    end
  endtask

  // Reset in the middle of a call's EXEC, then in the middle of a stalled FETCH.
  task automatic test_reset_mid();
    rec_t r; exp_t o; int n;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) gen(4'd10, 4'd0, 0, -1, 0, -1);
      else           gen(4'd3, 4'd0, 3, -1, 0, -1);
      for (n = 0; n < ((pass == 0) ? 6 : 2); n++) begin
        r = sb.pop_front();
        @(posedge clk); #1;
        mem_ready = r.mem_ready; stall = r.stall; irq = r.irq; instr = r.instr; status_reg = r.status;
        #1 o = observe();
        checks++;
        if (o !== r.e) begin
          errors++;
          $display("FAIL rstmid%0d cyc %0d got %h exp %h", pass, n, o, r.e);
        end
      end
      sb.delete();
      #1 rst_n = 1'b0;
      mem_ready = 1'b0; stall = 1'b0; irq = 1'b0;
      #1 o = observe();
      checks++;
      if (o !== 17'd0) begin
        errors++;
        $display("FAIL rstmid%0d_async got %h exp %h", pass, o, 17'd0);
      end
      cur_opc = 4'd0; cur_br = 1'b0; pend_ill = 1'b0;
      @(negedge clk) rst_n = 1'b1;
    end
    gen(4'd11, 4'd0, 0, -1, 0, -1);
    n = 0;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      @(posedge clk); #1;
      mem_ready = r.mem_ready; stall = r.stall; irq = r.irq; instr = r.instr; status_reg = r.status;
      #1 o = observe();
      checks++; n++;
      if (o !== r.e) begin
        errors++;
        $display("FAIL rst_recover cyc %0d got %h exp %h", n, o, r.e);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_stall();
    test_illegal();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
